// File: rtl/mbe_mult_arbiter.sv
// Two-requester round-robin front end for a shared 11x11 radix-4 Booth mantissa multiplier,
// with credit-based issue and per-requester FWFT response FIFOs. Define MBE_MULT_ARB_STATS_EN for counters.

module mbe_rad4_mult (
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [21:0] product
);
  logic [12:0] bx;
  logic [21:0] acc;
  logic [21:0] pp;
  logic [2:0]  grp;

  // Product fits in 22 bits, so modulo-2^22 accumulation of signed partial products is exact.
  always_comb begin
    bx  = {1'b0, b, 1'b0};
    acc = '0;
    pp  = '0;
    grp = '0;
    for (int unsigned j = 0; j < 6; j++) begin
      grp = bx[2*j +: 3];
      case (grp)
        3'b001, 3'b010: pp = {11'b0, a};
        3'b011:         pp = {10'b0, a, 1'b0};
        3'b100:         pp = ~{10'b0, a, 1'b0} + 22'd1;
        3'b101, 3'b110: pp = ~{11'b0, a} + 22'd1;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*j));
    end
    product = acc;
  end
endmodule

module mbe_mult_arbiter #(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MBE_MULT_ARB_STATS_EN
  input  logic                  stat_clear,
  output logic [1:0][15:0]      stat_grants,
  output logic [1:0][15:0]      stat_stalls,
`endif
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][10:0]      req_a,
  input  logic [1:0][10:0]      req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][21:0]      rsp_product,
  output logic [1:0][TAG_W-1:0] rsp_tag
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             rr;

  logic             s0_valid;
  logic             s0_owner;
  logic [10:0]      s0_a;
  logic [10:0]      s0_b;
  logic [TAG_W-1:0] s0_tag;
  logic [21:0]      mult_p;

  logic             fin_valid;
  logic             fin_owner;
  logic [TAG_W-1:0] fin_tag;
  logic [21:0]      fin_product;

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (eligible == 2'b11) grant[rr] = 1'b1;
      else                   grant     = eligible;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst)           rr <= 1'b0;
    else if (grant[0]) rr <= 1'b1;
    else if (grant[1]) rr <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_owner <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_tag   <= '0;
    end else begin
      s0_valid <= |grant;
      if (|grant) begin
        s0_owner <= grant[1];
        s0_a     <= req_a[grant[1]];
        s0_b     <= req_b[grant[1]];
        s0_tag   <= req_tag[grant[1]];
      end
    end
  end

  mbe_rad4_mult u_mult (
    .a       (s0_a),
    .b       (s0_b),
    .product (mult_p)
  );

  // The FIFO write is the last of the PIPE_STAGES product registers, so only
  // PIPE_STAGES-1 explicit stages sit between the multiplier and the FIFOs.
  if (PIPE_STAGES == 1) begin : g_direct
    assign fin_valid   = s0_valid;
    assign fin_owner   = s0_owner;
    assign fin_tag     = s0_tag;
    assign fin_product = mult_p;
  end else begin : g_pipe
    localparam int unsigned N = PIPE_STAGES - 1;
    logic [N-1:0]            v;
    logic [N-1:0]            own;
    logic [N-1:0][TAG_W-1:0] tg;
    logic [N-1:0][21:0]      pr;

    always_ff @(posedge clk) begin
      if (rst) begin
        v   <= '0;
        own <= '0;
        tg  <= '0;
        pr  <= '0;
      end else begin
        v[0]   <= s0_valid;
        own[0] <= s0_owner;
        tg[0]  <= s0_tag;
        pr[0]  <= mult_p;
        for (int unsigned k = 1; k < N; k++) begin
          v[k]   <= v[k-1];
          own[k] <= own[k-1];
          tg[k]  <= tg[k-1];
          pr[k]  <= pr[k-1];
        end
      end
    end

    assign fin_valid   = v[N-1];
    assign fin_owner   = own[N-1];
    assign fin_tag     = tg[N-1];
    assign fin_product = pr[N-1];
  end

  for (genvar i = 0; i < 2; i++) begin : g_req
    logic [CW-1:0]                   inflight_q;
    logic [CW-1:0]                   count_q;
    logic [PW-1:0]                   wr_ptr;
    logic [PW-1:0]                   rd_ptr;
    logic [FIFO_DEPTH-1:0][21:0]     mem_p;
    logic [FIFO_DEPTH-1:0][TAG_W-1:0] mem_t;
    logic                            push;
    logic                            pop;
    logic                            head_valid;

    assign push        = fin_valid && (fin_owner == 1'(i));
    assign head_valid  = (count_q != '0);
    assign pop         = head_valid && rsp_ready[i];
    assign eligible[i] = req_valid[i] && ((inflight_q + count_q) < CW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        inflight_q <= '0;
        count_q    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (grant[i] && !push)      inflight_q <= inflight_q + 1'b1;
        else if (!grant[i] && push) inflight_q <= inflight_q - 1'b1;
        if (push && !pop)           count_q    <= count_q + 1'b1;
        else if (!push && pop)      count_q    <= count_q - 1'b1;
        if (push)                   wr_ptr     <= wr_ptr + 1'b1;
        if (pop)                    rd_ptr     <= rd_ptr + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_p[wr_ptr] <= fin_product;
        mem_t[wr_ptr] <= fin_tag;
      end
    end

    assign rsp_valid[i]   = head_valid;
    assign rsp_product[i] = head_valid ? mem_p[rd_ptr] : '0;
    assign rsp_tag[i]     = head_valid ? mem_t[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

`ifdef MBE_MULT_ARB_STATS_EN
    logic [15:0] grants_q;
    logic [15:0] stalls_q;

    always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
        grants_q <= '0;
        stalls_q <= '0;
      end else begin
        if (grant[i] && (grants_q != '1))                  grants_q <= grants_q + 1'b1;
        if (req_valid[i] && !grant[i] && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
      end
    end

    assign stat_grants[i] = grants_q;
    assign stat_stalls[i] = stalls_q;
`endif
  end
endmodule

// File: tb/tb_mbe_mult_arbiter.sv
// Directed self-checking bench for mbe_mult_arbiter (PIPE_STAGES=2, FIFO_DEPTH=4, TAG_W=4).
// Statistics checks are compiled in when MBE_MULT_ARB_STATS_EN is defined.

module tb_mbe_mult_arbiter;
  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][10:0] req_a;
  logic [1:0][10:0] req_b;
  logic [1:0][3:0] req_tag;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [1:0][21:0] rsp_product;
  logic [1:0][3:0] rsp_tag;
`ifdef MBE_MULT_ARB_STATS_EN
  logic            stat_clear;
  logic [1:0][15:0] stat_grants;
  logic [1:0][15:0] stat_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] t0_a [4] = '{11'h7FF, 11'h001, 11'h400, 11'h123};
  logic [10:0] t0_b [4] = '{11'h7FF, 11'h7FF, 11'h002, 11'h456};
  logic [21:0] t0_p [4] = '{22'h3FF001, 22'h0007FF, 22'h000800, 22'h04EDC2};
  logic [10:0] t1_a [4] = '{11'h000, 11'h555, 11'h7FE, 11'h3AB};
  logic [10:0] t1_b [4] = '{11'h7FF, 11'h2AA, 11'h003, 11'h001};
  logic [21:0] t1_p [4] = '{22'h000000, 22'h0E3472, 22'h0017FA, 22'h0003AB};

  always #5 clk = ~clk;

  mbe_mult_arbiter #(
    .PIPE_STAGES (2),
    .FIFO_DEPTH  (4),
    .TAG_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef MBE_MULT_ARB_STATS_EN
    .stat_clear  (stat_clear),
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_tag     (rsp_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_tag = '0;
`ifdef MBE_MULT_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; req_a = '0; req_b = '0; req_tag = '0;
`ifdef MBE_MULT_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    tick(); tick(); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_product !== '0 || rsp_tag !== '0) begin
      n_fail++; $display("FAIL reset_rsp_data: product=%h tag=%h want 0", rsp_product, rsp_tag); end
    rst = 1'b0; req_valid = '0; rsp_ready = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_a[0] = 11'h7FF; req_b[0] = 11'h7FF; req_tag[0] = 4'd3; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_accept: got %b want 01", req_ready); end
    tick(); req_valid = '0; #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_lat_t1: rsp_valid=%b want 00", rsp_valid); end
    tick(); #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_lat_t2: rsp_valid=%b want 00", rsp_valid); end
    tick(); #1;
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_lat_t3: rsp_valid=%b want 01", rsp_valid); end
    n_checks++; if (rsp_product[0] !== 22'h3FF001 || rsp_tag[0] !== 4'd3) begin
      n_fail++; $display("FAIL single_data: product=%h tag=%h want 3ff001 tag 3", rsp_product[0], rsp_tag[0]); end
    rsp_ready = 2'b01;
    tick(); rsp_ready = '0; #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_pop: rsp_valid=%b want 00", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int a0 = 0, a1 = 0, rx0 = 0, rx1 = 0;
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 14; k++) begin
      req_valid = (k < 8) ? {a1 < 4, a0 < 4} : 2'b00;
      req_a[0] = t0_a[a0 % 4]; req_b[0] = t0_b[a0 % 4]; req_tag[0] = 4'(a0 + 1);
      req_a[1] = t1_a[a1 % 4]; req_b[1] = t1_b[a1 % 4]; req_tag[1] = 4'(a1 + 9);
      #1;
      if (k < 8) begin
        n_checks++; if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10); end
      end
      if (req_ready[0]) a0++;
      if (req_ready[1]) a1++;
      if (rsp_valid[0]) begin
        n_checks++; if (rx0 >= 4 || rsp_product[0] !== t0_p[rx0 % 4] || rsp_tag[0] !== 4'(rx0 + 1)) begin
          n_fail++; $display("FAIL rr_rsp0 #%0d: product=%h tag=%h want %h tag %h", rx0, rsp_product[0], rsp_tag[0], t0_p[rx0 % 4], 4'(rx0 + 1)); end
        rx0++;
      end
      if (rsp_valid[1]) begin
        n_checks++; if (rx1 >= 4 || rsp_product[1] !== t1_p[rx1 % 4] || rsp_tag[1] !== 4'(rx1 + 9)) begin
          n_fail++; $display("FAIL rr_rsp1 #%0d: product=%h tag=%h want %h tag %h", rx1, rsp_product[1], rsp_tag[1], t1_p[rx1 % 4], 4'(rx1 + 9)); end
        rx1++;
      end
      tick();
    end
    n_checks++; if (rx0 != 4 || rx1 != 4) begin
      n_fail++; $display("FAIL rr_rsp_count: got %0d/%0d want 4/4", rx0, rx1); end
  endtask

  task automatic test_credit();
    int n0 = 0;
    do_reset();
    rsp_ready = 2'b10;
    req_a[1] = 11'd1; req_b[1] = 11'd1; req_tag[1] = 4'd0; req_b[0] = 11'd3;
    for (int k = 0; k < 16; k++) begin
      req_valid = 2'b11; req_a[0] = 11'(10 + n0); req_tag[0] = 4'(n0);
      #1;
      if (k >= 12) begin
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL credit_block k=%0d: got %b want 10", k, req_ready); end
      end
      if (req_ready[0]) n0++;
      tick();
    end
    n_checks++; if (n0 != 4) begin n_fail++; $display("FAIL credit_accepts: got %0d want 4", n0); end
    rsp_ready = 2'b11; req_a[0] = 11'(10 + n0); req_tag[0] = 4'(n0);
    #1;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL credit_pop_cycle: req_ready0=%b want 0", req_ready[0]); end
    n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_product[0] !== 22'd30 || rsp_tag[0] !== 4'd0) begin
      n_fail++; $display("FAIL credit_head: valid=%b product=%h tag=%h want 1 %h 0", rsp_valid[0], rsp_product[0], rsp_tag[0], 22'd30); end
    tick(); rsp_ready = 2'b10; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL credit_resume: got %b want 01", req_ready); end
    tick(); #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL credit_one_per_pop: got %b want 10", req_ready); end
    n_checks++; if (rsp_product[0] !== 22'd33) begin n_fail++; $display("FAIL credit_next_head: got %h want %h", rsp_product[0], 22'd33); end
    req_valid = '0;
  endtask

  task automatic test_push_pop_full();
    int n0 = 0;
    logic [6:0] exp_acc = 7'b1001111;
    do_reset();
    req_b[0] = 11'd5;
    for (int c = 0; c < 10; c++) begin
      req_valid = (n0 < 5) ? 2'b01 : 2'b00;
      req_a[0] = 11'(20 + n0); req_tag[0] = 4'(n0);
      rsp_ready = (c == 5) ? 2'b01 : 2'b00;
      #1;
      if (c < 7) begin
        n_checks++; if (req_ready[0] !== exp_acc[c]) begin
          n_fail++; $display("FAIL full_accept c=%0d: got %b want %b", c, req_ready[0], exp_acc[c]); end
      end
      if (c == 5) begin
        n_checks++; if (rsp_product[0] !== 22'd100 || rsp_tag[0] !== 4'd0) begin
          n_fail++; $display("FAIL full_pop_head: product=%h tag=%h want %h 0", rsp_product[0], rsp_tag[0], 22'd100); end
      end
      if (c == 6) begin
        n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_product[0] !== 22'd105) begin
          n_fail++; $display("FAIL full_pushpop_head: valid=%b product=%h want 1 %h", rsp_valid[0], rsp_product[0], 22'd105); end
      end
      if (req_ready[0]) n0++;
      tick();
    end
    rsp_ready = 2'b01;
    for (int j = 1; j < 5; j++) begin
      #1;
      n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_product[0] !== 22'(100 + 5*j) || rsp_tag[0] !== 4'(j)) begin
        n_fail++; $display("FAIL full_drain #%0d: valid=%b product=%h tag=%h want 1 %h %h", j, rsp_valid[0], rsp_product[0], rsp_tag[0], 22'(100 + 5*j), 4'(j)); end
      tick();
    end
    #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL full_empty: rsp_valid=%b want 00", rsp_valid); end
    rsp_ready = '0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_a[0] = 11'd7; req_b[0] = 11'd7; req_tag[0] = 4'd5;
    req_a[1] = 11'd3; req_b[1] = 11'd3; req_tag[1] = 4'd6;
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_ready: got %b want 00", req_ready); end
    tick(); rst = 1'b0; req_valid = '0; #1;
    n_checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL midrst_cleared: rsp_valid=%b req_ready=%b want 00 00", rsp_valid, req_ready); end
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_stale c=%0d: rsp_valid=%b want 00", c, rsp_valid); end
    end
    req_a[0] = 11'd5; req_b[0] = 11'd9; req_tag[0] = 4'hA; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_fresh_accept: got %b want 01", req_ready); end
    tick(); req_valid = '0; tick(); tick(); #1;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_product[0] !== 22'd45 || rsp_tag[0] !== 4'hA) begin
      n_fail++; $display("FAIL midrst_fresh_rsp: valid=%b product=%h tag=%h want 01 %h a", rsp_valid, rsp_product[0], rsp_tag[0], 22'd45); end
    rsp_ready = 2'b01; tick(); rsp_ready = '0; #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL midrst_drained: rsp_valid=%b want 00", rsp_valid); end
  endtask

`ifdef MBE_MULT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    rsp_ready = 2'b11;
    req_a[0] = 11'd1; req_b[0] = 11'd1; req_a[1] = 11'd2; req_b[1] = 11'd2;
    for (int c = 0; c < 13; c++) begin req_valid = 2'b01; tick(); end
    for (int c = 0; c < 14; c++) begin req_valid = 2'b11; tick(); end
    req_valid = '0; #1;
    n_checks++; if (stat_grants[0] !== 16'd20) begin n_fail++; $display("FAIL stat_grants0: got %0d want 20", stat_grants[0]); end
    n_checks++; if (stat_stalls[1] !== 16'd7) begin n_fail++; $display("FAIL stat_stalls1: got %0d want 7", stat_stalls[1]); end
    n_checks++; if (stat_grants[1] !== 16'd7 || stat_stalls[0] !== 16'd7) begin
      n_fail++; $display("FAIL stat_other: grants1=%0d stalls0=%0d want 7 7", stat_grants[1], stat_stalls[0]); end
    stat_clear = 1'b1; tick(); stat_clear = 1'b0; #1;
    n_checks++; if (stat_grants !== '0 || stat_stalls !== '0) begin
      n_fail++; $display("FAIL stat_clear: grants=%h stalls=%h want 0", stat_grants, stat_stalls); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_push_pop_full();
    test_reset_midop();
`ifdef MBE_MULT_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
